wb_regfile: RTL and testbench
=============================

# wb_regfile

Writeback stage and architectural register file for the 64-bit pipelined processor. It consumes the MEM/WB pipeline register outputs and selects the writeback value (ALU result or load data). It commits that value to a 32×64 register file on the rising clock edge and serves the two decode-stage read ports. It also keeps a retired-write counter for debug and performance visibility.

## Interface

**Parameters**
- `XLEN`, default 64: data width of registers and writeback path.
- `NREGS`, default 32: number of architectural registers; x0 is hardwired to zero.

**Ports**
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: reset is asynchronous and active-low; clears all state while low.
- `Result2` input XLEN: ALU result from MEM/WB.
- `Read_Data2` input XLEN: load data from MEM/WB.
- `rd2` input 5: destination register index from MEM/WB.
- `MemtoReg2` input 1: 1 selects `Read_Data2`, 0 selects `Result2`.
- `RegWrite2` input 1: write enable for this writeback.
- `rs1` input 5: read port A index (decode stage).
- `rs2` input 5: read port B index (decode stage).
- `ReadData1` output XLEN: register[rs1], combinational.
- `ReadData2` output XLEN: register[rs2], combinational.
- `WriteData` output XLEN: selected writeback value, combinational; for debug and forwarding.
- `retire_cnt` output 32: count of committed (non-x0) writes.

## Operation

- Writeback select: `WriteData` is `Read_Data2` when `MemtoReg2` is 1, otherwise `Result2`.
- Commit:
  - A write occurs at posedge `clk` when `RegWrite2`=1 and `rd2`≠0.
  - The write stores `WriteData` into register[`rd2`].
- x0:
  - Never written.
  - Reads of index 0 return 0 regardless of any write attempt.
  - A write attempt to x0 with `RegWrite2`=1 does not increment `retire_cnt`.
- Reads: `ReadData1` and `ReadData2` are purely combinational from the array, or from the bypass when enabled (see Configuration).
- `retire_cnt`:
  - Increments by 1 on each committed write.
  - Wraps from 0xFFFF_FFFF to 0 with no saturation and no flag.
- Reset:
  - While `reset`=0, all registers, including `retire_cnt`, are asynchronously cleared to 0.
  - Writes are suppressed while `reset` is low.
  - Reset values: `ReadData1`=`ReadData2`=0 for every index; `retire_cnt`=0; `WriteData` follows its inputs (combinational).
  - Reset asserted in the same cycle as a pending write: reset wins, and the register stays 0.
  - Reset deasserted: the first possible write is at the first rising edge where `reset`=1.
- Same-index read on both ports returns identical data.

## Timing

- Write latency: value is visible in the array 1 cycle after the commit edge.
- Read latency: 0 cycles (combinational from `rs1`/`rs2`).
- Read-during-write to the same index in the same cycle:
  - Without bypass: returns the old value.
  - With bypass: returns `WriteData`.
- `retire_cnt` updates on the same edge as the commit.
- No handshake: `RegWrite2` acts as the valid qualifier. The block never stalls.

## Configuration

- Macro: `WB_REGFILE_BYPASS_EN`.
- Defined:
  - If `RegWrite2`=1, `rd2`≠0, and `rs1`==`rd2`, then `ReadData1`=`WriteData`.
  - Same rule for `rs2`/`ReadData2`.
  - This removes the one-cycle WB→ID hazard.
- Undefined:
  - Reads always come from the array.
  - The hazard unit must stall one cycle on WB→ID dependencies.

## Structure

- Shared package `cpu_pkg`:
  - `XLEN`
  - `NREGS`
  - `REG_IDX_W` (=5)
  - typedef `reg_idx_t` (5 bits)
  - typedef `xdata_t` (XLEN bits)
  - `ZERO_REG` constant (0)
- One sub-module, `reg_array`:
  - NREGS×XLEN storage.
  - Asynchronous active-low clear.
  - One write port, two combinational read ports.
  - x0 masking.
- The top level holds the writeback mux, bypass logic, and `retire_cnt`.

## Test plan

- Reset low for 3 cycles, then high → `ReadData1`/`ReadData2` = 0 for rs = 0..31; `retire_cnt`=0.
- `RegWrite2`=1, `rd2`=5, `MemtoReg2`=0, `Result2`=0x1234 → after the edge, reading rs1=5 gives 0x1234 and `retire_cnt`=1. Repeat with `MemtoReg2`=1, `Read_Data2`=0xDEAD_BEEF → reading 5 gives 0xDEAD_BEEF.
- Write to rd2=0 with `Result2`=0xFFFF → reading rs1=0 gives 0; `retire_cnt` unchanged.
- Same-cycle read/write, rs1=rs2=7, writing 0xAA to rd2=7 (old value 0x55):
  - With `WB_REGFILE_BYPASS_EN`: both ports give 0xAA.
  - Without it: both ports give 0x55 that cycle and 0xAA the next cycle.
- Assert reset mid-stream after writing 0x99 to x10 → `ReadData1` (rs1=10) becomes 0 immediately, without waiting for an edge; `retire_cnt`=0.
- Force `retire_cnt` to 0xFFFF_FFFF via 2^32−1 writes (or a backdoor preload), then one more commit → `retire_cnt`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the writeback / register-file slice.
package cpu_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xdata_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/wb_regfile_reg_array.sv
// Architectural register storage: NREGS x XLEN, one write port, two
// combinational read ports, async active-low clear, x0 reads as zero.
module reg_array
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we_i,
    input  logic [REG_IDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]      wdata_i,
    input  logic [REG_IDX_W-1:0] raddr_a_i,
    input  logic [REG_IDX_W-1:0] raddr_b_i,
    output logic [XLEN-1:0]      rdata_a_o,
    output logic [XLEN-1:0]      rdata_b_o
);

    logic [NREGS-1:0][XLEN-1:0] mem_q;

    // Storage: cleared while reset is low; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '0;
        end else if (we_i && (waddr_i != ZERO_REG)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read ports: index 0 is masked so x0 always reads zero.
    always_comb begin
        rdata_a_o = '0;
        rdata_b_o = '0;
        if (raddr_a_i != ZERO_REG) rdata_a_o = mem_q[raddr_a_i];
        if (raddr_b_i != ZERO_REG) rdata_b_o = mem_q[raddr_b_i];
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage + register file: writeback mux, commit to reg_array,
// optional WB->ID read bypass, and a wrapping retired-write counter.
// Optional feature macro: WB_REGFILE_BYPASS_EN (read bypass of WriteData).
module wb_regfile
    import cpu_pkg::*;
#(
    parameter int XLEN  = cpu_pkg::XLEN,
    parameter int NREGS = cpu_pkg::NREGS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [XLEN-1:0]      Result2,
    input  logic [XLEN-1:0]      Read_Data2,
    input  logic [REG_IDX_W-1:0] rd2,
    input  logic                 MemtoReg2,
    input  logic                 RegWrite2,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    output logic [XLEN-1:0]      ReadData1,
    output logic [XLEN-1:0]      ReadData2,
    output logic [XLEN-1:0]      WriteData,
    output logic [31:0]          retire_cnt
);

    logic            commit;
    logic [XLEN-1:0] arr_rd1, arr_rd2;
    logic [31:0]     retire_cnt_q, retire_cnt_d;

    assign WriteData = MemtoReg2 ? Read_Data2 : Result2;
    assign commit    = RegWrite2 && (rd2 != ZERO_REG);

    reg_array #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_reg_array (
        .clk       (clk),
        .rst_n     (reset),
        .we_i      (commit),
        .waddr_i   (rd2),
        .wdata_i   (WriteData),
        .raddr_a_i (rs1),
        .raddr_b_i (rs2),
        .rdata_a_o (arr_rd1),
        .rdata_b_o (arr_rd2)
    );

`ifdef WB_REGFILE_BYPASS_EN
    // Forward the in-flight writeback to a matching read so decode sees it this cycle.
    always_comb begin
        ReadData1 = arr_rd1;
        ReadData2 = arr_rd2;
        if (commit && (rs1 == rd2)) ReadData1 = WriteData;
        if (commit && (rs2 == rd2)) ReadData2 = WriteData;
    end
`else
    // No bypass: reads come straight from the array; hazard unit covers WB->ID.
    always_comb begin
        ReadData1 = arr_rd1;
        ReadData2 = arr_rd2;
    end
`endif

    // Retired-write counter next state: wraps naturally at 32 bits.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit) retire_cnt_d = retire_cnt_q + 32'd1;
    end

    // Retired-write counter register, cleared with the register file.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: scoreboard of expected read/writeback
// values against a small behavioural register-file model.
module tb_wb_regfile;
    import cpu_pkg::*;

    logic            clk = 1'b0;
    logic            reset;
    logic [63:0]     Result2, Read_Data2;
    logic [4:0]      rd2, rs1, rs2;
    logic            MemtoReg2, RegWrite2;
    logic [63:0]     ReadData1, ReadData2, WriteData;
    logic [31:0]     retire_cnt;

    int checks   = 0;
    int failures = 0;

    logic [63:0] model [32];
    logic [31:0] mcnt;
    logic [63:0] exp_q [$];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk        (clk),
        .reset      (reset),
        .Result2    (Result2),
        .Read_Data2 (Read_Data2),
        .rd2        (rd2),
        .MemtoReg2  (MemtoReg2),
        .RegWrite2  (RegWrite2),
        .rs1        (rs1),
        .rs2        (rs2),
        .ReadData1  (ReadData1),
        .ReadData2  (ReadData2),
        .WriteData  (WriteData),
        .retire_cnt (retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mdl(input logic [4:0] idx);
        return (idx == 5'd0) ? 64'd0 : model[idx];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 64'd0;
        mcnt = 32'd0;
    endtask

    // Drive read indices, queue the expected data, then pop and compare.
    task automatic rd_check(input string tag, input logic [4:0] a, input logic [4:0] b);
        rs1 = a;
        rs2 = b;
        exp_q.push_back(mdl(a));
        exp_q.push_back(mdl(b));
        #1;
        chk({tag, "_rd1"}, ReadData1, exp_q.pop_front());
        chk({tag, "_rd2"}, ReadData2, exp_q.pop_front());
    endtask

    // One writeback beat; called at a negedge, returns at the following negedge.
    task automatic do_write(input string tag, input logic [4:0] rd, input logic m2r,
                            input logic [63:0] res, input logic [63:0] ld);
        rd2 = rd; MemtoReg2 = m2r; Result2 = res; Read_Data2 = ld; RegWrite2 = 1'b1;
        exp_q.push_back(m2r ? ld : res);
        #1;
        chk({tag, "_wdata"}, WriteData, exp_q.pop_front());
        @(posedge clk);
        if (rd != 5'd0) begin
            model[rd] = m2r ? ld : res;
            mcnt = mcnt + 32'd1;
        end
        @(negedge clk);
        RegWrite2 = 1'b0;
        exp_q.push_back({32'd0, mcnt});
        #1;
        chk({tag, "_cnt"}, {32'd0, retire_cnt}, exp_q.pop_front());
    endtask

    initial begin
        reset = 1'b0; RegWrite2 = 1'b0; MemtoReg2 = 1'b0;
        Result2 = '0; Read_Data2 = '0; rd2 = '0; rs1 = '0; rs2 = '0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Reset state: every index reads zero, counter zero.
        for (int i = 0; i < 32; i++) rd_check("rst", 5'(i), 5'(31 - i));
        chk("rst_cnt", {32'd0, retire_cnt}, 64'd0);

        // ALU-result and load-data writeback to x5.
        do_write("alu5", 5'd5, 1'b0, 64'h1234, 64'h0BAD);
        rd_check("alu5", 5'd5, 5'd5);
        chk("alu5_one", {32'd0, retire_cnt}, 64'd1);
        do_write("ld5", 5'd5, 1'b1, 64'h0BAD, 64'hDEAD_BEEF);
        rd_check("ld5", 5'd5, 5'd0);

        // x0 write attempt: ignored, counter unchanged.
        do_write("x0", 5'd0, 1'b0, 64'hFFFF, 64'd0);
        rd_check("x0", 5'd0, 5'd0);
        chk("x0_cnt", {32'd0, retire_cnt}, 64'd2);

        // Same-cycle read/write of x7 (old 0x55, new 0xAA).
        do_write("x7old", 5'd7, 1'b0, 64'h55, 64'd0);
        rd2 = 5'd7; MemtoReg2 = 1'b0; Result2 = 64'hAA; RegWrite2 = 1'b1;
        rs1 = 5'd7; rs2 = 5'd7;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        chk("raw_same_rd1", ReadData1, 64'hAA);
        chk("raw_same_rd2", ReadData2, 64'hAA);
`else
        chk("raw_same_rd1", ReadData1, 64'h55);
        chk("raw_same_rd2", ReadData2, 64'h55);
`endif
        @(posedge clk);
        model[7] = 64'hAA; mcnt = mcnt + 32'd1;
        @(negedge clk);
        RegWrite2 = 1'b0;
        rd_check("raw_next", 5'd7, 5'd7);

        // Randomised write/read stream against the model.
        for (int i = 0; i < 40; i++) begin
            do_write("rnd", 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                     {$urandom, $urandom}, {$urandom, $urandom});
            rd_check("rnd", 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Mid-cycle asynchronous reset after writing 0x99 to x10.
        do_write("x10", 5'd10, 1'b0, 64'h99, 64'd0);
        rd_check("x10", 5'd10, 5'd10);
        #2;
        reset = 1'b0;
        #1;
        chk("async_rd1", ReadData1, 64'd0);
        chk("async_cnt", {32'd0, retire_cnt}, 64'd0);
        model_clear();

        // Pending write held across an edge while in reset: reset wins.
        rd2 = 5'd3; Result2 = 64'h77; MemtoReg2 = 1'b0; RegWrite2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rd_check("rst_wr", 5'd3, 5'd10);
        chk("rst_wr_cnt", {32'd0, retire_cnt}, 64'd0);

        // Release reset with the write still pending: first rising edge commits.
        reset = 1'b1;
        @(posedge clk);
        model[3] = 64'h77; mcnt = 32'd1;
        @(negedge clk);
        RegWrite2 = 1'b0;
        rd_check("post_rst", 5'd3, 5'd3);
        chk("post_rst_cnt", {32'd0, retire_cnt}, 64'd1);

        // Counter wrap via backdoor preload.
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        mcnt = 32'hFFFF_FFFF;
        chk("wrap_pre", {32'd0, retire_cnt}, 64'h0000_0000_FFFF_FFFF);
        @(negedge clk);
        do_write("wrap", 5'd4, 1'b0, 64'h4444, 64'd0);
        chk("wrap_zero", {32'd0, retire_cnt}, 64'd0);
        rd_check("wrap", 5'd4, 5'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
